ps2_host_tx: RTL

- Host-to-device PS/2 transmitter: the outbound half of the mouse link, complementing the existing device-to-host receive path inside the mouse controller.
- Sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting) to the mouse.
- Implements the request-to-send sequence, clocks out the data/parity/stop bits on device clock edges, and checks the device line-ack.
- Drives PS2_CLK/PS2_DATA open-drain through output-enable signals; top level forms the inout tristates (drive 0 when oe=1, else Z).

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 50 +++++
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host link.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RESP_ACK   = 8'hFA;

    // Cycles at the end of the inhibit window during which the start bit is driven.
    localparam int START_LEAD = 16;

    // Outbound frame, LSB first: data d0..d7, odd parity, stop.
    function automatic logic [9:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions a raw PS/2 clock pad: 2-flop synchronizer, stability filter and
// a one-cycle strobe on each accepted 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // The synchronized sample has differed from the filtered level long enough.
    assign accept = (sync_q[1] != level_q) && (cnt_q == CW'(FILTER_LEN - 1));

    // Synchronize, count consecutive differing samples, and update the filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus is high; resetting to 1 keeps reset from faking a falling edge.
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            sync_q <= {sync_q[0], line_i};
            fall_q <= accept && level_q;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device
// clock falls, line-ack check and timeout. Lines are driven open-drain via oe.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // CLK_HZ only documents the clock the default cycle counts assume.
    if (CLK_HZ <= 0) begin : g_clk_hz_unset
    end

    state_t        state_q, state_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    data_sync_q;
    logic          clk_level;
    logic          clk_fall;
    logic          timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_i),
        .level_o(clk_level),
        .fall_o (clk_fall)
    );

    // Two-flop synchronizer for the data pad (no filtering needed: sampled mid-bit).
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Next-state and datapath decisions for the transmit sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));

        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                timer_d   = '0;
                bit_cnt_d = '0;
                if (tx_valid) begin
                    shreg_d = make_frame(tx_data);
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(INHIBIT_CYCLES - START_LEAD - 1)) begin
                    data_oe_d = 1'b1;
                end
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                timer_d = timer_q + 1'b1;
                if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[9:1]};
                    end
                end
            end
            ACK: begin
                timer_d = timer_q + 1'b1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (data_sync_q[1]) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                timer_d = timer_q + 1'b1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (clk_level && data_sync_q[1]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT);
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule
